// File: rtl/uart_apb_regfifo.sv
// UART APB3 register block with TX/RX FIFOs, W1C sticky status and FIFO level reporting.
// Define UART_REGFIFO_IRQ_EN to add the IER register and the registered irq output.
module uart_apb_regfifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_valid,
  input  logic              set_tx_done,
  input  logic              set_rx_done,
  input  logic              set_parity_error,
  output logic [4:0]        cfg_out,
  output logic              irq
);

  localparam int unsigned TX_PW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_PW + 1;
  localparam int unsigned RX_PW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_PW + 1;
  localparam int unsigned WW    = ADDR_W - 2;

  typedef enum logic [WW-1:0] {
    REG_TXDATA = WW'(0),
    REG_RXDATA = WW'(1),
    REG_CFG    = WW'(2),
    REG_CTRL   = WW'(3),
    REG_STAT   = WW'(4),
    REG_LEVEL  = WW'(5),
    REG_IER    = WW'(6)
  } reg_e;

  logic [WW-1:0] word;
  logic          access, wr_acc, rd_acc;

  assign word   = paddr[ADDR_W-1:2];
  assign access = psel & penable;
  assign wr_acc = access & pwrite;
  assign rd_acc = access & ~pwrite;
  assign pready = 1'b1;

  logic [4:0] cfg_q;
  logic       tx_en_q;
  logic [5:0] sticky_q;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]  tx_wptr, tx_rptr;
  logic [TX_CW-1:0]  tx_count;
  logic tx_empty, tx_full, tx_flush, tx_push_req, tx_push, tx_pop, tx_ovf;

  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_flush    = wr_acc & (word == REG_CTRL) & pwdata[1];
  assign tx_push_req = wr_acc & (word == REG_TXDATA);
  assign tx_push     = tx_push_req & ~tx_full & ~tx_flush;
  assign tx_ovf      = tx_push_req & tx_full;
  assign tx_valid    = tx_en_q & ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready & ~tx_flush;
  assign tx_data_out = tx_empty ? '0 : tx_mem[tx_rptr];

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wptr] <= pwdata[DATA_W-1:0];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]  rx_wptr, rx_rptr;
  logic [RX_CW-1:0]  rx_count;
  logic [DATA_W-1:0] rx_head;
  logic rx_empty, rx_full, rx_flush, rx_push, rx_pop_req, rx_pop, rx_ovf, rx_unf;

  assign rx_empty   = (rx_count == '0);
  assign rx_full    = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_flush   = wr_acc & (word == REG_CTRL) & pwdata[2];
  assign rx_push    = rx_valid & ~rx_full & ~rx_flush;
  assign rx_ovf     = rx_valid & rx_full;
  assign rx_pop_req = rd_acc & (word == REG_RXDATA);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_unf     = rx_pop_req & rx_empty;
  assign rx_head    = rx_empty ? '0 : rx_mem[rx_rptr];

  always_ff @(posedge pclk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data_in;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);
    end
  end

  // ---------------- Control / status registers ----------------
  logic [5:0] stat_set, stat_clr;

  assign stat_set = {rx_unf, tx_ovf, rx_ovf, set_parity_error, set_rx_done, set_tx_done};
  assign stat_clr = (wr_acc && (word == REG_STAT)) ? pwdata[5:0] : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cfg_q    <= '0;
      tx_en_q  <= 1'b0;
      sticky_q <= '0;
      cfg_out  <= '0;
    end else begin
      // set is OR'd after the clear so a same-cycle event wins over W1C
      sticky_q <= (sticky_q & ~stat_clr) | stat_set;
      cfg_out  <= cfg_q;
      if (wr_acc && (word == REG_CFG))  cfg_q   <= pwdata[4:0];
      if (wr_acc && (word == REG_CTRL)) tx_en_q <= pwdata[0];
    end
  end

`ifdef UART_REGFIFO_IRQ_EN
  logic [5:0] ier_q;
  logic       irq_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(sticky_q & ier_q);
      if (wr_acc && (word == REG_IER)) ier_q <= pwdata[5:0];
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------- Read mux / error ----------------
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (word)
        REG_TXDATA: pslverr = tx_ovf;
        REG_RXDATA: begin
          if (!pwrite) prdata = 32'(rx_head);
          pslverr = rx_unf;
        end
        REG_CFG:   prdata = {27'b0, cfg_q};
        REG_CTRL:  prdata = {31'b0, tx_en_q};
        REG_STAT:  prdata = {20'b0, rx_full, rx_empty, tx_full, tx_empty, 2'b0, sticky_q};
        REG_LEVEL: begin
          prdata[7:0]   = 8'(tx_count);
          prdata[23:16] = 8'(rx_count);
        end
        REG_IER: begin
`ifdef UART_REGFIFO_IRQ_EN
          prdata = {26'b0, ier_q};
`endif
        end
        default: pslverr = 1'b1;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, pwdata, paddr[1:0]};

endmodule

// File: tb/tb_uart_apb_regfifo.sv
// Randomized self-checking bench for uart_apb_regfifo against a queue-based reference model.
// Honours UART_REGFIFO_IRQ_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_apb_regfifo;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TX_DEPTH = 16;
  localparam int unsigned RX_DEPTH = 16;
  localparam int unsigned ADDR_W   = 5;

  logic              pclk = 1'b0;
  logic              presetn = 1'b1;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [DATA_W-1:0] tx_data_out;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data_in = '0;
  logic              rx_valid = 1'b0;
  logic              set_tx_done = 1'b0, set_rx_done = 1'b0, set_parity_error = 1'b0;
  logic [4:0]        cfg_out;
  logic              irq;

  always #5 pclk = ~pclk;

  uart_apb_regfifo #(
    .DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data_out(tx_data_out), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data_in(rx_data_in), .rx_valid(rx_valid), .set_tx_done(set_tx_done),
    .set_rx_done(set_rx_done), .set_parity_error(set_parity_error),
    .cfg_out(cfg_out), .irq(irq)
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [DATA_W-1:0] txq[$];
  logic [DATA_W-1:0] rxq[$];
  logic [5:0]  m_sticky, m_ier;
  logic [4:0]  m_cfg, m_cfg_out;
  logic        m_tx_en, m_irq;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_sticky = '0; m_ier = '0; m_cfg = '0; m_cfg_out = '0; m_tx_en = 1'b0; m_irq = 1'b0;
  endtask

  // One clock: check outputs before the edge, advance the model, return 1ns after the edge.
  task automatic step();
    logic acc, wr, rd, tx_full, rx_full, rx_was_empty, exp_txv, ev_tx_ovf, ev_rx_ovf, ev_rx_unf;
    logic [2:0]  w;
    logic [5:0]  clr;
    logic [31:0] exp_rd;
    logic        exp_err;
    @(negedge pclk);
    acc = psel && penable;
    wr  = acc && pwrite;
    rd  = acc && !pwrite;
    w   = paddr[4:2];
    tx_full      = (txq.size() == TX_DEPTH);
    rx_full      = (rxq.size() == RX_DEPTH);
    rx_was_empty = (rxq.size() == 0);
    exp_txv      = m_tx_en && (txq.size() != 0);
    ev_tx_ovf    = wr && (w == 3'd0) && tx_full;
    ev_rx_unf    = rd && (w == 3'd1) && rx_was_empty;
    ev_rx_ovf    = rx_valid && rx_full;

    check_eq("pready", 32'(pready), 32'd1);
    check_eq("tx_valid", 32'(tx_valid), 32'(exp_txv));
    if (exp_txv) check_eq("tx_data_out", 32'(tx_data_out), 32'(txq[0]));
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq("cfg_out", 32'(cfg_out), 32'(m_cfg_out));
    if (acc) begin
      exp_rd  = '0;
      exp_err = 1'b0;
      case (w)
        3'd0: exp_err = ev_tx_ovf;
        3'd1: if (!pwrite) begin
          exp_err = ev_rx_unf;
          if (!rx_was_empty) exp_rd = 32'(rxq[0]);
        end
        3'd2: exp_rd = 32'(m_cfg);
        3'd3: exp_rd = 32'(m_tx_en);
        3'd4: exp_rd = {20'd0, rx_full, rx_was_empty, tx_full, (txq.size() == 0), 2'b00, m_sticky};
        3'd5: exp_rd = (32'(rxq.size()) << 16) | 32'(txq.size());
`ifdef UART_REGFIFO_IRQ_EN
        3'd6: exp_rd = 32'(m_ier);
`else
        3'd6: exp_rd = '0;
`endif
        default: exp_err = 1'b1;
      endcase
      if (!pwrite) check_eq("prdata", prdata, exp_rd);
      check_eq("pslverr", 32'(pslverr), 32'(exp_err));
      last_rdata = prdata;
      last_err   = pslverr;
    end

`ifdef UART_REGFIFO_IRQ_EN
    m_irq = |(m_sticky & m_ier);
`else
    m_irq = 1'b0;
`endif
    m_cfg_out = m_cfg;
    clr = (wr && w == 3'd4) ? pwdata[5:0] : 6'd0;
    if (wr && w == 3'd3 && pwdata[1]) txq.delete();
    else begin
      if (exp_txv && tx_ready) void'(txq.pop_front());
      if (wr && w == 3'd0 && !tx_full) txq.push_back(pwdata[DATA_W-1:0]);
    end
    if (wr && w == 3'd3 && pwdata[2]) rxq.delete();
    else begin
      if (rd && w == 3'd1 && !rx_was_empty) void'(rxq.pop_front());
      if (rx_valid && !rx_full) rxq.push_back(rx_data_in);
    end
    m_sticky = (m_sticky & ~clr) | {ev_rx_unf, ev_tx_ovf, ev_rx_ovf, set_parity_error, set_rx_done, set_tx_done};
    if (wr && w == 3'd2) m_cfg = pwdata[4:0];
    if (wr && w == 3'd3) m_tx_en = pwdata[0];
`ifdef UART_REGFIFO_IRQ_EN
    if (wr && w == 3'd6) m_ier = pwdata[5:0];
`endif
    @(posedge pclk);
    #1;
    rx_valid = 1'b0; set_tx_done = 1'b0; set_rx_done = 1'b0; set_parity_error = 1'b0;
  endtask

  task automatic apb_setup(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
  endtask

  task automatic apb_access();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    apb_setup(1'b1, a, d);
    apb_access();
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a);
    apb_setup(1'b0, a, 32'd0);
    apb_access();
  endtask

  task automatic rand_side();
    rx_valid         = ($urandom_range(0, 2) == 0);
    rx_data_in       = DATA_W'($urandom);
    set_tx_done      = ($urandom_range(0, 7) == 0);
    set_rx_done      = ($urandom_range(0, 7) == 0);
    set_parity_error = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_prdata"}, prdata, 32'd0);
    check_eq({tag, "_pslverr"}, 32'(pslverr), 32'd0);
    check_eq({tag, "_pready"}, 32'(pready), 32'd1);
    check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(tx_data_out), 32'd0);
    check_eq({tag, "_cfg_out"}, 32'(cfg_out), 32'd0);
    check_eq({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2 presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_reset_outputs("rst");
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk);
    #1;

    apb_read(5'h10);
    check_eq("stat_reset", last_rdata, 32'h0000_0500);
    apb_read(5'h14);
    check_eq("level_reset", last_rdata, 32'd0);

    // TX fill past full, then drain
    for (int i = 0; i < 16; i++) apb_write(5'h00, 32'h11 + 32'(i));
    apb_write(5'h00, 32'h21);
    check_eq("tx_ovf_err", 32'(last_err), 32'd1);
    apb_read(5'h14);
    check_eq("level_tx16", last_rdata, 32'h10);
    apb_read(5'h10);
    check_eq("stat_txfull_ovf", last_rdata & 32'h210, 32'h210);
    tx_ready = 1'b1;
    apb_write(5'h0C, 32'h1);
    for (int i = 0; i < 16; i++) begin
      check_eq("tx_seq_valid", 32'(tx_valid), 32'd1);
      check_eq("tx_seq_data", 32'(tx_data_out), 32'h11 + 32'(i));
      step();
    end
    check_eq("tx_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    apb_write(5'h0C, 32'h0);

    // RX push / read / underflow
    rx_data_in = 8'hA5; rx_valid = 1'b1; step();
    rx_data_in = 8'h5A; rx_valid = 1'b1; step();
    apb_read(5'h04);
    check_eq("rx_rd0", last_rdata, 32'hA5);
    apb_read(5'h04);
    check_eq("rx_rd1", last_rdata, 32'h5A);
    apb_read(5'h04);
    check_eq("rx_unf_data", last_rdata, 32'd0);
    check_eq("rx_unf_err", 32'(last_err), 32'd1);
    apb_read(5'h10);
    check_eq("stat_rx_unf", (last_rdata >> 5) & 32'd1, 32'd1);

    // RX overflow, W1C, set-beats-clear
    for (int i = 0; i < 16; i++) begin
      rx_data_in = DATA_W'($urandom); rx_valid = 1'b1; step();
    end
    rx_data_in = 8'h77; rx_valid = 1'b1; step();
    apb_read(5'h10);
    check_eq("stat_rx_ovf_full", last_rdata & 32'h808, 32'h808);
    apb_write(5'h10, 32'h08);
    apb_read(5'h10);
    check_eq("stat_rx_ovf_clr", (last_rdata >> 3) & 32'd1, 32'd0);
    apb_setup(1'b1, 5'h10, 32'h01);
    set_tx_done = 1'b1;
    apb_access();
    apb_read(5'h10);
    check_eq("stat_set_wins", last_rdata & 32'd1, 32'd1);

    // interrupt
    apb_write(5'h18, 32'h02);
    apb_write(5'h10, 32'h3F);
    set_rx_done = 1'b1; step();
    step();
`ifdef UART_REGFIFO_IRQ_EN
    check_eq("irq_set", 32'(irq), 32'd1);
    apb_write(5'h10, 32'h02);
    check_eq("irq_hold", 32'(irq), 32'd1);
    step();
    check_eq("irq_clr", 32'(irq), 32'd0);
`else
    check_eq("irq_tied", 32'(irq), 32'd0);
    apb_read(5'h18);
    check_eq("ier_absent", last_rdata, 32'd0);
`endif

    // RX flush on full FIFO with a simultaneous push
    apb_setup(1'b1, 5'h0C, 32'h4);
    rx_data_in = 8'h33; rx_valid = 1'b1;
    apb_access();
    apb_read(5'h14);
    check_eq("flush_rx_count", (last_rdata >> 16) & 32'hFF, 32'd0);
    apb_read(5'h10);
    check_eq("flush_rx_empty", (last_rdata >> 10) & 32'd1, 32'd1);
    apb_read(5'h0C);
    check_eq("flush_ctrl_rd", last_rdata, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  w;
      logic [31:0] d;
      logic        wrb;
      tx_ready = ($urandom_range(0, 1) == 1);
      w   = 3'($urandom_range(0, 7));
      wrb = ($urandom_range(0, 1) == 1);
      d   = $urandom;
      if (w == 3'd3 && $urandom_range(0, 3) != 0) d[2:1] = 2'b00;
      rand_side();
      apb_setup(wrb, {w, 2'($urandom)}, d);
      rand_side();
      apb_access();
      if ($urandom_range(0, 3) == 0) begin
        rand_side();
        step();
      end
    end
    tx_ready = 1'b0;

    // asynchronous reset in the middle of an access
    apb_write(5'h08, 32'h1F);
    apb_write(5'h0C, 32'h1);
    apb_write(5'h00, 32'h5C);
    apb_setup(1'b0, 5'h10, 32'd0);
    penable = 1'b1;
    @(negedge pclk);
    #1;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk);
    #1;
    apb_read(5'h10);
    check_eq("stat_after_midrst", last_rdata, 32'h0000_0500);
    apb_read(5'h14);
    check_eq("level_after_midrst", last_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_regfifo.md
Name: uart_apb_regfifo

Overview:
Parametrised next-generation APB3 register block for the UART. It replaces single-entry TX/RX data registers with TX and RX FIFOs of configurable depth and width. It adds write-1-to-clear sticky status, overflow and underflow detection, and FIFO level reporting. It sits between the APB slave port and the UART TX/RX cores.

Parameters:
DATA_W, 8, UART character width; legal range 5..16; FIFO entry width.
TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.
ADDR_W, 5, APB byte-address width.

Ports:
pclk  in  1  APB clock; the only clock.
presetn  in  1  asynchronous active-low reset.
psel  in  1  APB select.
penable  in  1  APB enable; access phase = psel & penable.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address; bits [1:0] ignored.
pwdata  in  32  write data.
prdata  out  32  read data; combinational, valid during the access phase.
pready  out  1  tied 1; zero wait states.
pslverr  out  1  combinational error flag, valid during the access phase.
tx_data_out  out  DATA_W  TX FIFO head.
tx_valid  out  1  equals CTRL.tx_en & !tx_empty.
tx_ready  in  1  TX core accepts the head; pops when tx_valid & tx_ready.
rx_data_in  in  DATA_W  received character.
rx_valid  in  1  1-cycle push strobe.
set_tx_done  in  1  pulse from the TX core.
set_rx_done  in  1  pulse from the RX core.
set_parity_error  in  1  pulse from the RX core.
cfg_out  out  5  CFG[4:0]; registered copy.
irq  out  1  interrupt; level-high.

Behaviour:
- Register map (word offsets):
  - 0x00 TXDATA, WO. A write pushes pwdata[DATA_W-1:0]. Reads return 0.
  - 0x04 RXDATA, RO. A read returns the head zero-extended and pops it. Writes are ignored with no error.
  - 0x08 CFG, RW [4:0]: data_bits[1:0] (00=5 .. 11=8), stop_bits[2], parity_en[3], parity_odd[4].
  - 0x0C CTRL, RW [0] tx_en. Bits [1] tx_flush and [2] rx_flush are write-1, self-clearing, and read as 0.
  - 0x10 STAT:
    - W1C sticky bits: [0] tx_done, [1] rx_done, [2] parity_err, [3] rx_ovf, [4] tx_ovf, [5] rx_unf.
    - RO bits: [8] tx_empty, [9] tx_full, [10] rx_empty, [11] rx_full.
  - 0x14 LEVEL, RO: [7:0] tx_count, [23:16] rx_count.
  - 0x18 IER, RW [5:0]: per-bit enable for STAT[5:0].
  - Unmapped offsets: read 0, write ignored, pslverr=1.
- Reset values:
  - All registers 0, except STAT[8] and STAT[10], which reset to 1.
  - FIFOs empty; pointers and counts 0.
  - All outputs 0, except pready=1.
- Register updates happen on the pclk edge ending the access phase. The setup phase (psel & !penable) has no effect.
- TX FIFO:
  - A write while full: data dropped, STAT.tx_ovf set, pslverr=1.
  - A core pop and an APB push in the same cycle are both performed; count unchanged.
  - Full and empty are evaluated on the pre-edge count. A pop does not make room for a same-cycle push on a full FIFO.
- RX FIFO:
  - rx_valid while full: character dropped, STAT.rx_ovf set.
  - A read while empty: prdata=0, STAT.rx_unf set, pslverr=1, no pointer movement.
  - Simultaneous push and pop follow the same rule as the TX FIFO.
- Pointers wrap modulo depth. Count width is clog2(depth)+1 and saturates at depth.
- Flush empties the FIFO in one cycle. A push in the same cycle as a flush is discarded. A flush does not change sticky bits.
- Sticky bit set and W1C on the same bit in the same cycle: set wins.
- The set_* pulses OR into STAT[2:0]; repeated pulses are idempotent.
- cfg_out lags CFG by 1 cycle.
- tx_data_out is valid whenever tx_valid=1 and holds stable until popped.
- Asserting presetn low mid-transfer clears everything asynchronously. Outputs return to reset values immediately.

Optional Feature:
UART_REGFIFO_IRQ_EN.
- Defined: irq is a registered |(STAT[5:0] & IER[5:0]), 1-cycle latency. It clears 1 cycle after the W1C of the last enabled set bit.
- Undefined: IER is absent (0x18 reads 0, writes ignored, pslverr=0) and irq is tied 0.

Test Plan:
- Reset, then read 0x10 -> prdata=0x0000_0500. Read 0x14 -> 0.
- tx_en=0; write 0x11..0x20 to TXDATA (TX_DEPTH=16). Then write 0x21 -> LEVEL.tx=16, STAT[9]=1, pslverr=1 on the 17th write, STAT[4]=1. Set tx_en=1 with tx_ready=1 -> tx_data_out sequence 0x11..0x20, one per cycle, then tx_valid=0.
- Push 0xA5 and 0x5A via rx_valid. Read RXDATA three times -> 0xA5, 0x5A, then 0 with pslverr=1 and STAT[5]=1.
- Fill RX, pulse rx_valid with 0x77 -> dropped, STAT[3]=1. Write 0x08 to STAT -> STAT[3]=0. Same-cycle set_tx_done and W1C bit0 -> STAT[0] stays 1.
- With IRQ_EN: IER=0x02, pulse set_rx_done -> irq=1 next cycle. W1C 0x02 -> irq=0 one cycle later. Without IRQ_EN: irq stays 0.
- Write CTRL=0x4 on a full RX FIFO with a simultaneous rx_valid -> rx_count=0, STAT[10]=1, CTRL reads 0.
